// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_if
//  Description : Signal bundle between the raw button board and the
//                debouncer. The debouncer sits on the slave side: it reads
//                the raw pins and drives the debounced state and strobes.
//  Signals     : button_in     [7:0] raw active-low pins (0 = pressed)
//                btn_out       [7:0] debounced state, active-high
//                press_pulse   [7:0] one-cycle strobe per accepted press
//                release_pulse [7:0] one-cycle strobe per accepted release
//                changed             OR of all press/release strobes
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_debounce_if;
   logic [7:0] button_in;
   logic [7:0] btn_out;
   logic [7:0] press_pulse;
   logic [7:0] release_pulse;
   logic       changed;

   modport master (
      output button_in,
      input  btn_out,
      input  press_pulse,
      input  release_pulse,
      input  changed
   );

   modport slave (
      input  button_in,
      output btn_out,
      output press_pulse,
      output release_pulse,
      output changed
   );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Eight independent button debouncers. Each raw pin is
//                synchronised through two flops, inverted to active-high and
//                compared with the accepted state; a change is accepted only
//                after DEBOUNCE_CYCLES consecutive mismatched samples.
//  Parameters  : DEBOUNCE_CYCLES  stable samples needed (1 .. 2^CNT_W-1)
//                CNT_W            per-button counter width
//  Ports       : clk    sampling clock (10 kHz divided clock)
//                reset  asynchronous, active-low
//                bus    button_debounce_if.slave (pins in, state/strobes out)
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int CNT_W           = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   button_debounce_if.slave   bus
);

   // Count value at which the next mismatched sample accepts the change.
   localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0] r_sync_meta;
   logic [7:0] r_sync;
   logic [7:0] w_btn;
   logic [7:0] w_press;
   logic [7:0] w_release;

   // Synchronizer resets to all-ones, i.e. every button released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync_meta <= 8'hFF;
         r_sync      <= 8'hFF;
      end else begin
         r_sync_meta <= bus.button_in;
         r_sync      <= r_sync_meta;
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_bit
      logic [CNT_W-1:0] r_cnt;
      logic             r_btn;
      logic             r_press;
      logic             r_release;
      logic             w_mismatch;

      // Pins are active-low, the accepted state is active-high.
      assign w_mismatch = (~r_sync[i]) != r_btn;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt     <= '0;
            r_btn     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_mismatch) begin
               // Any agreeing sample (bounce) restarts the stability run.
               r_cnt <= '0;
            end else if (r_cnt == c_last) begin
               r_cnt     <= '0;
               r_btn     <= ~r_btn;
               r_press   <= ~r_btn;
               r_release <= r_btn;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end

      assign w_btn[i]     = r_btn;
      assign w_press[i]   = r_press;
      assign w_release[i] = r_release;
   end

   assign bus.btn_out       = w_btn;
   assign bus.press_pulse   = w_press;
   assign bus.release_pulse = w_release;
   // Derived from registered strobes only, so it is clean for one cycle.
   assign bus.changed       = |(w_press | w_release);

endmodule
`default_nettype wire

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20, giving the number of consecutive stable cycles needed to accept a change (2 ms at 10 kHz).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the per-button counter width; DEBOUNCE_CYCLES SHALL be in the range 1 to 2^CNT_W-1.
REQ-003 Port: clk  input  1  sampling clock, the 10 kHz divided clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: button_in  input  8  raw button-board pins; active-low (0 = pressed); asynchronous to clk; may bounce.
REQ-006 Port: btn_out  output  8  debounced state; active-high (1 = pressed); feeds the multiplexer b_mux input directly.
REQ-007 Port: press_pulse  output  8  one-cycle strobe per bit on an accepted press.
REQ-008 Port: release_pulse  output  8  one-cycle strobe per bit on an accepted release.
REQ-009 Port: changed  output  1  OR of all press_pulse and release_pulse bits, same cycle.

Function
REQ-010 Each button_in bit SHALL pass through a two-flop synchronizer; the second-stage value is "sync[i]".
REQ-011 All 8 bits SHALL be processed independently, each with its own CNT_W-bit counter cnt[i]; no shared state between bits.
REQ-012 A bit is mismatched when ~sync[i] != btn_out[i]; on any edge where bit i is not mismatched, cnt[i] SHALL clear to 0.
REQ-013 On an edge where bit i is mismatched and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 On an edge where bit i is mismatched and cnt[i] == DEBOUNCE_CYCLES-1, btn_out[i] SHALL toggle and cnt[i] SHALL clear to 0.
REQ-015 On that same edge, press_pulse[i] (if the new value is 1) or release_pulse[i] (if the new value is 0) SHALL assert for exactly one cycle.
REQ-016 Latency: a pin change held stable SHALL appear on btn_out on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new pin level as edge 1.
REQ-017 A pin excursion stable for fewer than DEBOUNCE_CYCLES sampled cycles SHALL NOT change btn_out or produce any pulse; bounce restarts the count from 0.
REQ-018 The counter SHALL never wrap; with DEBOUNCE_CYCLES=1, a single mismatched sync cycle toggles the output.
REQ-019 Multiple bits MAY toggle on the same edge; each asserts its own pulse, and changed asserts once for that cycle.
REQ-020 press_pulse[i] and release_pulse[i] SHALL never be high simultaneously; btn_out SHALL be glitch-free, driven directly from flops.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force synchronizer flops to 8'hFF (released), all cnt to 0, btn_out to 8'h00, press_pulse and release_pulse to 8'h00, and changed to 0.
REQ-022 Reset asserted mid-count SHALL discard partial counts, with no pulse on reset assertion or deassertion.
REQ-023 A button held through reset release SHALL be reported as a normal press DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Clean press: button_in 8'hFF -> 8'hFE held -> btn_out becomes 8'h01 on edge 6 after the sampling edge, with press_pulse=8'h01 and changed=1 for one cycle only.
REQ-025 Bounce rejection: bit 3 low for 3 cycles, high for 1, low for 3, then high -> btn_out stays 8'h00 and no pulses occur.
REQ-026 Release: from btn_out=8'h01, button_in returns to 8'hFF -> btn_out=8'h00 after 6 edges, with release_pulse=8'h01 for one cycle.
REQ-027 Simultaneous: button_in 8'hFF -> 8'h5A in one step -> btn_out=8'hA5 and press_pulse=8'hA5 on the same edge, and changed high for one cycle.
REQ-028 Reset mid-count: bit 0 low, reset asserted after 2 counted cycles -> outputs 0 immediately; after release with bit 0 still low, press is reported 6 edges later.
REQ-029 Random bounce: random per-bit glitches shorter than 4 cycles mixed with stable holds -> a scoreboard confirms btn_out matches the reference model and the pulse count equals the toggle count.
